// File: rtl/sdio_dat_tx_lane.sv
// Single-lane SDIO DAT write transmitter: start bit, MSB-first payload, CRC16 shifted
// out of the external per-lane CRC unit, end bit, then one driven period before release.
module sdio_dat_tx_lane (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       start_i,
  input  logic [9:0] block_size_i,
  input  logic       bit_en_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       sd_dat_o,
  output logic       sd_dat_oe_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       underrun_o,
  output logic       crc_data_o,
  output logic       crc_sample_o,
  output logic       crc_clr_o,
  output logic       crc_shift_o,
  input  logic       crc_serial_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_CRC,
    S_END,
    S_RELEASE
  } state_e;

  state_e      state_q;
  logic [10:0] count_q;
  logic [10:0] fetched_q;
  logic [10:0] sent_q;
  logic [2:0]  bit_idx_q;
  logic [3:0]  crc_cnt_q;
  logic [7:0]  hold_q;
  logic        hold_vld_q;
  logic [7:0]  shift_q;
  logic        sd_dat_q;
  logic        sd_oe_q;
  logic        busy_q;
  logic        done_q;
  logic        underrun_q;

  logic in_fetch;
  logic handshake;
  logic boundary;
  logic send_bit;
  logic cur_bit;
  logic last_byte;

  assign in_fetch     = (state_q == S_START) || (state_q == S_DATA);
  assign data_ready_o = in_fetch && !hold_vld_q && (fetched_q < count_q);
  assign handshake    = data_ready_o && data_valid_i;
  assign boundary     = (bit_idx_q == 3'd0);
  // At a byte boundary the bit comes straight from the hold register.
  assign cur_bit      = boundary ? hold_q[7] : shift_q[7];
  assign send_bit     = (state_q == S_DATA) && bit_en_i && !(boundary && !hold_vld_q);
  assign last_byte    = ((sent_q + 11'd1) == count_q);

  assign crc_clr_o    = (state_q == S_IDLE) && start_i;
  assign crc_sample_o = send_bit;
  assign crc_data_o   = send_bit && cur_bit;
  assign crc_shift_o  = (state_q == S_CRC) && bit_en_i;

  assign sd_dat_o     = sd_dat_q;
  assign sd_dat_oe_o  = sd_oe_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign underrun_o   = underrun_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      count_q    <= 11'd0;
      fetched_q  <= 11'd0;
      sent_q     <= 11'd0;
      bit_idx_q  <= 3'd0;
      crc_cnt_q  <= 4'd0;
      hold_q     <= 8'd0;
      hold_vld_q <= 1'b0;
      shift_q    <= 8'd0;
      sd_dat_q   <= 1'b1;
      sd_oe_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (handshake) begin
        hold_q     <= data_i;
        hold_vld_q <= 1'b1;
        fetched_q  <= fetched_q + 11'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            count_q    <= {1'b0, block_size_i} + 11'd1;
            fetched_q  <= 11'd0;
            sent_q     <= 11'd0;
            bit_idx_q  <= 3'd0;
            hold_vld_q <= 1'b0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (bit_en_i) begin
            sd_dat_q  <= 1'b0;
            sd_oe_q   <= 1'b1;
            bit_idx_q <= 3'd0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_en_i) begin
            if (boundary && !hold_vld_q) begin
              // Starved at a byte boundary: a byte accepted this same cycle is dropped.
              underrun_q <= 1'b1;
              sd_dat_q   <= 1'b1;
              sd_oe_q    <= 1'b0;
              busy_q     <= 1'b0;
              hold_vld_q <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              sd_dat_q <= cur_bit;
              if (boundary) begin
                shift_q    <= {hold_q[6:0], 1'b0};
                hold_vld_q <= 1'b0;
              end else begin
                shift_q <= {shift_q[6:0], 1'b0};
              end
              bit_idx_q <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) begin
                sent_q <= sent_q + 11'd1;
                if (last_byte) begin
                  crc_cnt_q <= 4'd15;
                  state_q   <= S_CRC;
                end
              end
            end
          end
        end
        S_CRC: begin
          if (bit_en_i) begin
            sd_dat_q <= crc_serial_i;
            if (crc_cnt_q == 4'd0) begin
              state_q <= S_END;
            end else begin
              crc_cnt_q <= crc_cnt_q - 4'd1;
            end
          end
        end
        S_END: begin
          if (bit_en_i) begin
            sd_dat_q <= 1'b1;
            state_q  <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (bit_en_i) begin
            sd_oe_q <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdio_dat_tx_lane.md
# sdio_dat_tx_lane

Single-lane SDIO DAT transmitter for write data blocks. Accepts bytes from the uDMA TX path over a valid/ready stream and serialises them MSB-first on one DAT line: start bit, payload, 16-bit CRC, end bit, then line release. It is the direct upstream driver of the per-lane CRC16 unit (polynomial x^16+x^12+x^5+1, init 0). It drives that unit's data/sample/clear/shift controls and shifts out the CRC from its serial MSB output. A bit strobe from the SD clock generator paces the transmission.

## Interface
- No parameters.
- clk_i  in  1  system clock
- rstn_i  in  1  reset, asynchronous, active-low
- start_i  in  1  start a block; honoured only in IDLE
- block_size_i  in  10  payload bytes minus 1 (1..1024 bytes); sampled on accepted start
- bit_en_i  in  1  bit strobe; one DAT bit advances per asserted cycle; may be high every cycle
- data_i  in  8  payload byte
- data_valid_i  in  1  byte valid
- data_ready_o  out  1  byte accept
- sd_dat_o  out  1  DAT line value (registered)
- sd_dat_oe_o  out  1  DAT output enable, active-high (registered)
- busy_o  out  1  high from accepted start until return to IDLE
- done_o  out  1  one-cycle pulse on normal completion
- underrun_o  out  1  sticky abort flag; cleared by next accepted start
- crc_data_o  out  1  bit to CRC unit
- crc_sample_o  out  1  CRC sample strobe (combinational)
- crc_clr_o  out  1  CRC clear strobe (combinational)
- crc_shift_o  out  1  CRC shift strobe (combinational)
- crc_serial_i  in  1  CRC register MSB from CRC unit

## Operation
- States: IDLE, START, DATA, CRC, END, RELEASE.
- IDLE: start_i=1 -> crc_clr_o=1 same cycle. Latch byte count = block_size_i+1. Clear underrun_o and counters. Go to START.
- Byte buffering uses a hold register (hold_q, hold_vld) plus an 8-bit shift register.
  - data_ready_o = (state in START/DATA) & !hold_vld & fetched < count.
  - A handshake loads hold_q and sets hold_vld.
- START, on bit_en_i: sd_dat_o<=0, sd_dat_oe_o<=1, go to DATA with bit index 0.
- DATA, on bit_en_i at a byte boundary (bit index 0):
  - If hold_vld is set (registered value): move hold_q to the shift register and clear hold_vld in the same edge. Drive the MSB.
  - Otherwise this is an underrun: underrun_o<=1, sd_dat_o<=1, sd_dat_oe_o<=0, go to IDLE, no done_o. A byte handshaked in that same cycle does not count as available and is discarded.
- DATA, each bit sent: sd_dat_o<=bit, with crc_sample_o=1 and crc_data_o=bit in the same cycle.
- After bit 7 of the last byte, go to CRC with counter 15.
- CRC, on bit_en_i: sd_dat_o<=crc_serial_i and crc_shift_o=1. After 16 bits go to END.
- END, on bit_en_i: sd_dat_o<=1 (end bit), go to RELEASE.
- RELEASE, on bit_en_i: sd_dat_oe_o<=0, done_o=1 for one cycle, go to IDLE.
- crc_sample_o, crc_shift_o and crc_clr_o are mutually exclusive. They are 0 whenever bit_en_i=0, except crc_clr_o.
- start_i while busy: ignored.
- Counters: fetched and sent byte counts are 11 bits; bit index 3 bits; CRC count 4 bits. None wrap within a block.

## Timing
- Reset values: sd_dat_o=1, sd_dat_oe_o=0, data_ready_o=0, busy_o=0, done_o=0, underrun_o=0, all crc_* outputs 0, state IDLE.
- Latency:
  - Start bit appears on the first bit_en_i edge after the start cycle.
  - The first payload bit appears on the next bit_en_i.
- Total line bits per block: 1 + 8*(N) + 16 + 1, where N = block_size_i+1. Then one further bit period driven before release.
- CRC MSB is valid on crc_serial_i the cycle after the last sample. The first CRC bit_en_i may directly follow the last data bit_en_i.
- busy_o is high from the cycle after start until the RELEASE edge. It falls together with the done_o pulse.
- Reset mid-block: immediate return to reset values. No done_o.

## Test plan
- 1 byte 0x00, bit_en_i every cycle, data pre-offered -> DAT sequence 0, 00000000, 16×0, 1. OE high for 27 bit periods, then done_o pulse.
- 1 byte 0x80 -> payload 10000000, CRC bits 0x9188 MSB first, end bit 1.
- 512 bytes incrementing 0x00..0xFF, bit_en_i every 4th cycle -> 4115 bits. CRC matches the software CRC16 model.
- Data withheld at the second byte boundary -> underrun_o=1, OE drops on that edge, no done_o. The next start clears underrun_o.
- start_i pulsed mid-block and during RELEASE -> ignored. Byte count and CRC are unaffected.
- rstn_i asserted during the CRC phase -> outputs at reset values immediately. A subsequent block of 1 byte 0x80 still yields 0x9188.
